pci_arbiter: RTL and testbench
==============================

PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-002 The block SHALL have the port areset, input, 1 bit: reset, synchronous and active-high, sampled on posedge clk.
REQ-003 The block SHALL have the port req, input, 4 bits: per-device bus request, active-low, bit i = device i.
REQ-004 The block SHALL have the port Frame, input, 1 bit: shared PCI FRAME#, active-low; z/x is treated as 1 (released).
REQ-005 The block SHALL have the port IRDY, input, 1 bit: shared PCI IRDY#, active-low; z/x is treated as 1.
REQ-006 The block SHALL have the port addr_data, input, 32 bits: shared AD bus; only bits [5:4] are used, as the target index.
REQ-007 The block SHALL have the port gnt, output, 4 bits: per-device grant, active-low, registered.
REQ-008 The block SHALL have the port slotSel, output, 4 bits: per-device target select, active-high, registered.
REQ-009 The block SHALL have the port owner, output, 2 bits: index of the current or last granted device.
REQ-010 The block SHALL have the port addr_err, output, 1 bit: one-cycle pulse when the decoded target equals the initiator.

Function
REQ-011 The block SHALL implement the state machine IDLE, GRANT, BUSY, TURN, and SHALL hold gnt at a value with at most one bit 0 at all times.
REQ-012 In IDLE, the block SHALL hold gnt=4'b1111 and apply no bus parking.
REQ-013 In IDLE, when any req bit is 0, the block SHALL pick winner w by round-robin, searching from (owner+1) mod 4 upward with wrap 3->0.
REQ-014 On that IDLE pick, the block SHALL go to GRANT, assert gnt[w]=0 on the same edge, and load owner=w.
REQ-015 In GRANT, the block SHALL count cycles in a 4-bit wait counter cleared on GRANT entry.
REQ-016 In GRANT, when Frame=0 is sampled, the block SHALL go to BUSY.
REQ-017 In GRANT, when req[owner]=1 and Frame=1, the block SHALL go to IDLE with gnt=1111.
REQ-018 In GRANT, when the wait counter reaches 15 without Frame=0 (timeout), the block SHALL go to IDLE with gnt=1111, and owner SHALL keep w so the next pick skips w.
REQ-019 If Frame=0 and req[owner]=1 occur in the same GRANT cycle, the block SHALL give Frame priority and go to BUSY.
REQ-020 On the BUSY entry edge (first Frame=0 sample), the block SHALL latch t=addr_data[5:4].
REQ-021 On the next edge after BUSY entry, if t!=owner, the block SHALL drive slotSel[t]=1 for exactly one cycle; otherwise it SHALL drive slotSel=0000 and addr_err=1 for one cycle.
REQ-022 In BUSY, the block SHALL hold gnt[owner]=0 and SHALL ignore changes on req.
REQ-023 In BUSY, when Frame=1 and IRDY=1 are sampled together (bus idle), the block SHALL go to TURN and drive gnt=1111.
REQ-024 TURN SHALL last exactly one cycle with gnt=1111, then go to IDLE, guaranteeing at least one idle cycle between grants.
REQ-025 Latency from req low in IDLE to gnt low SHALL be 1 clk.
REQ-026 Latency from bus idle in BUSY to the next possible grant SHALL be 3 clk (TURN, IDLE, then grant).
REQ-027 The round-robin pointer arithmetic SHALL be 2-bit modulo-4 with natural wrap.

Reset
REQ-028 When areset=1, the block SHALL force state=IDLE, gnt=1111, slotSel=0000, addr_err=0, owner=3 (so device 0 wins first), and wait counter=0.
REQ-029 Reset SHALL override every transition; reset asserted mid-BUSY SHALL drop gnt to 1111 on the same edge.
REQ-030 After reset, arbitration SHALL resume on the first edge with areset=0.

Structure
REQ-031 A shared package pci_pkg SHALL hold the device count (4), the state encoding, the timeout value (15), and the target field position [5:4].
REQ-032 The round-robin winner search SHALL be one sub-module, rr_pick (inputs req and owner; outputs winner index and a valid flag), purely combinational.
REQ-033 Everything else SHALL be in pci_arbiter.

Verification
REQ-034 Bench scenario: after reset, req=1110 -> gnt=1110 one clk later, owner=0.
REQ-035 Bench scenario: req=0000 held, three transactions each completing (Frame low 2 cycles then Frame/IRDY high) -> grants in order 0,1,2 with 1 TURN cycle each.
REQ-036 Bench scenario: device 1 granted, Frame never falls -> gnt back to 1111 after 16 GRANT cycles; next grant goes to 2 if req=1001.
REQ-037 Bench scenario: device 0 in BUSY, addr_data=32'h20 -> slotSel=0100 pulse for 1 clk; with addr_data=32'h00 -> addr_err pulse and slotSel=0000.
REQ-038 Bench scenario: areset=1 mid-BUSY -> next edge gnt=1111, slotSel=0000, state IDLE, owner=3.
REQ-039 Bench scenario: req[owner] released in the same GRANT cycle that Frame=0 -> state BUSY and gnt held.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared constants and state encoding for the four-device PCI bus arbiter.
package pci_pkg;

    localparam int         NUM_DEV = 4;
    localparam logic [3:0] TIMEOUT = 4'd15;
    localparam int         TGT_LSB = 4;
    localparam int         TGT_MSB = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_TURN
    } state_t;

    // Active-low grant vector with only device idx pulled low.
    function automatic logic [3:0] grant_mask(input logic [1:0] idx);
        grant_mask = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Round-robin winner search: first active-low request after owner, wrapping 3->0.
module rr_pick
    import pci_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] owner,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Scan farthest-to-nearest so the device closest after owner is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner = owner;
        valid  = 1'b0;
        idx    = owner;
        for (int k = NUM_DEV; k >= 1; k--) begin
            idx = owner + 2'(k);
            if (!req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Four-device PCI bus arbiter: round-robin grants, grant timeout, one-cycle
// turnaround between owners and a registered target-select decode.
module pci_arbiter
    import pci_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic [3:0]  req,
    input  logic        Frame,
    input  logic        IRDY,
    input  logic [31:0] addr_data,
    output logic [3:0]  gnt,
    output logic [3:0]  slotSel,
    output logic [1:0]  owner,
    output logic        addr_err
);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [1:0] target;
    logic       decode_pend;
    logic       frame_low;
    logic       irdy_low;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       unused_ad;

    assign unused_ad = ^{addr_data[31:TGT_MSB+1], addr_data[TGT_LSB-1:0]};

    // A floating or unknown shared line counts as released: only a clean 0 is "asserted".
    always_comb begin
        case (Frame)
            1'b0:    frame_low = 1'b1;
            default: frame_low = 1'b0;
        endcase
        case (IRDY)
            1'b0:    irdy_low = 1'b1;
            default: irdy_low = 1'b0;
        endcase
    end

    rr_pick u_pick (
        .req    (req),
        .owner  (owner),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state       <= ST_IDLE;
            gnt         <= 4'b1111;
            slotSel     <= 4'b0000;
            addr_err    <= 1'b0;
            owner       <= 2'd3;
            wait_cnt    <= 4'd0;
            target      <= 2'd0;
            decode_pend <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; these pulse defaults are simply overridden by later assignments below.
            slotSel  <= 4'b0000;
            addr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gnt <= 4'b1111;
                    if (pick_valid) begin
                        state    <= ST_GRANT;
                        gnt      <= grant_mask(pick_idx);
                        owner    <= pick_idx;
                        wait_cnt <= 4'd0;
                    end
                end
                ST_GRANT: begin
                    if (frame_low) begin
                        state       <= ST_BUSY;
                        target      <= addr_data[TGT_MSB:TGT_LSB];
                        decode_pend <= 1'b1;
                    end else if (req[owner]) begin
                        state <= ST_IDLE;
                        gnt   <= 4'b1111;
                    end else if (wait_cnt == TIMEOUT) begin
                        // Owner keeps the timed-out device so the next search starts past it.
                        state <= ST_IDLE;
                        gnt   <= 4'b1111;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_BUSY: begin
                    if (decode_pend) begin
                        decode_pend <= 1'b0;
                        if (target != owner) slotSel  <= 4'b0001 << target;
                        else                 addr_err <= 1'b1;
                    end
                    if (!frame_low && !irdy_low) begin
                        state <= ST_TURN;
                        gnt   <= 4'b1111;
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 4'b1111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: a driver predicts grants and decodes from
// the arbitration rules, a negedge monitor compares whatever the DUT presents.
module tb_pci_arbiter;

    typedef enum int {K_DONE, K_SAME, K_REL, K_TMO} kind_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  req;
    logic        frame;
    logic        irdy;
    logic [31:0] addr_data;
    logic [3:0]  gnt;
    logic [3:0]  slot_sel;
    logic [1:0]  owner;
    logic        addr_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_owner;
    bit          noise_en = 1'b0;
    int          grant_q[$];
    logic [4:0]  dec_q[$];
    logic [3:0]  prev_gnt = 4'hF;
    int          mon_w;
    logic [4:0]  mon_e;

    pci_arbiter dut (
        .clk       (clk),
        .areset    (areset),
        .req       (req),
        .Frame     (frame),
        .IRDY      (irdy),
        .addr_data (addr_data),
        .gnt       (gnt),
        .slotSel   (slot_sel),
        .owner     (owner),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gmask(input int w);
        logic [3:0] m;
        m = 4'b0001 << w;
        return ~m;
    endfunction

    function automatic logic [3:0] sel_vec(input int t);
        logic [3:0] m;
        m = 4'b0001 << t;
        return m;
    endfunction

    // Reference rule: first requesting device strictly after the last owner, modulo 4.
    function automatic int rr_expect(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int d;
            d = (last + k) % 4;
            if (r[d] == 1'b0) return d;
        end
        return -1;
    endfunction

    function automatic logic [4:0] dec_expect(input logic [31:0] ad, input int w);
        int t;
        t = int'(ad[5:4]);
        if (t != w) return {sel_vec(t), 1'b0};
        return 5'b0000_1;
    endfunction

    // Monitor: grant rising out of all-released, and any decode pulse, are scoreboard events.
    always @(negedge clk) begin
        check("gnt_at_most_one_low", 32'($countones(~gnt) <= 1), 32'd1);
        if (prev_gnt == 4'hF && gnt != 4'hF) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", {28'd0, gnt}, 32'hF);
            end else begin
                mon_w = grant_q.pop_front();
                check("grant_vec", {28'd0, gnt}, {28'd0, gmask(mon_w)});
                check("grant_owner", {30'd0, owner}, 32'(mon_w));
            end
        end
        if (slot_sel != 4'b0000 || addr_err) begin
            if (dec_q.size() == 0) begin
                check("unexpected_decode", {27'd0, slot_sel, addr_err}, 32'd0);
            end else begin
                mon_e = dec_q.pop_front();
                check("decode_pulse", {27'd0, slot_sel, addr_err}, {27'd0, mon_e});
            end
        end
        prev_gnt = gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        req       = 4'hF;
        frame     = 1'b1;
        irdy      = 1'b1;
        addr_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {28'd0, gnt}, 32'hF);
        check("rst_slot", {28'd0, slot_sel}, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd3);
        areset      = 1'b0;
        model_owner = 3;
    endtask

    // Entered and left at posedge+1 with the arbiter idle.
    task automatic do_txn(input logic [3:0] r, input kind_t kind, input logic [31:0] ad);
        int         w;
        logic [4:0] e;
        w = rr_expect(r, model_owner);
        req = r;
        grant_q.push_back(w);
        model_owner = w;
        tick();
        check("grant_latency", {28'd0, gnt}, {28'd0, gmask(w)});
        case (kind)
            K_DONE, K_SAME: begin
                frame     = 1'b0;
                irdy      = 1'b0;
                addr_data = ad;
                if (kind == K_SAME) req = 4'hF;
                e = dec_expect(ad, w);
                dec_q.push_back(e);
                tick();
                check("busy_gnt_hold", {28'd0, gnt}, {28'd0, gmask(w)});
                check("no_early_decode", {27'd0, slot_sel, addr_err}, 32'd0);
                if (noise_en) req = 4'($urandom);
                tick();
                check("decode_timing", {27'd0, slot_sel, addr_err}, {27'd0, e});
                check("busy_gnt_hold", {28'd0, gnt}, {28'd0, gmask(w)});
                if ($urandom_range(0, 1) == 1) begin
                    if (noise_en) req = 4'($urandom);
                    tick();
                    check("busy_gnt_hold", {28'd0, gnt}, {28'd0, gmask(w)});
                end
                frame = 1'b1;
                req   = 4'hF;
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    check("irdy_low_hold", {28'd0, gnt}, {28'd0, gmask(w)});
                end
                irdy = 1'b1;
                tick();
                check("turn_gnt", {28'd0, gnt}, 32'hF);
                tick();
                check("idle_gap_gnt", {28'd0, gnt}, 32'hF);
            end
            K_REL: begin
                req = 4'hF;
                tick();
                check("release_gnt", {28'd0, gnt}, 32'hF);
            end
            default: begin
                repeat (15) begin
                    tick();
                    check("tmo_hold", {28'd0, gnt}, {28'd0, gmask(w)});
                end
                tick();
                check("tmo_release", {28'd0, gnt}, 32'hF);
                check("tmo_owner_kept", {30'd0, owner}, 32'(w));
                req = 4'hF;
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // First grant out of reset goes to device 0.
        do_txn(4'b1110, K_REL, 32'd0);

        // Everyone requesting: grants 0,1,2 each with a turnaround.
        do_reset();
        do_txn(4'b0000, K_DONE, 32'h0000_0030);
        do_txn(4'b0000, K_DONE, 32'h0000_0000);
        do_txn(4'b0000, K_DONE, 32'h0000_0010);

        // Device 1 times out, next search skips it.
        do_txn(4'b1101, K_TMO, 32'd0);
        do_txn(4'b1001, K_DONE, 32'h0000_0000);

        // Target decode and initiator-equals-target error.
        do_txn(4'b1110, K_DONE, 32'h0000_0020);
        do_txn(4'b1110, K_DONE, 32'h0000_0000);

        // Request dropped in the same cycle FRAME# falls.
        do_txn(4'b1011, K_SAME, 32'hFFFF_FF1F);

        // Reset in the middle of a busy transfer.
        req = 4'b1110;
        grant_q.push_back(rr_expect(4'b1110, model_owner));
        model_owner = 0;
        tick();
        frame     = 1'b0;
        irdy      = 1'b0;
        addr_data = 32'h0000_0020;
        tick();
        areset = 1'b1;
        tick();
        check("midbusy_rst_gnt", {28'd0, gnt}, 32'hF);
        check("midbusy_rst_slot", {28'd0, slot_sel}, 32'd0);
        check("midbusy_rst_err", {31'd0, addr_err}, 32'd0);
        check("midbusy_rst_owner", {30'd0, owner}, 32'd3);
        areset      = 1'b0;
        frame       = 1'b1;
        irdy        = 1'b1;
        req         = 4'hF;
        model_owner = 3;
        do_txn(4'b0110, K_DONE, 32'h0000_0010);

        // Randomized traffic with request noise during busy transfers.
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_txn(4'($urandom_range(0, 14)), kind_t'($urandom_range(0, 3)), $urandom);
        end

        repeat (3) tick();
        check("grant_q_drained", 32'(grant_q.size()), 32'd0);
        check("decode_q_drained", 32'(dec_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
